writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/rv32i_pkg.sv | 32 +++
 rtl/load_align.sv | 44 ++++
 rtl/writeback_unit.sv | 131 +++++++++++++
 tb/tb_writeback_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rv32i_pkg: load funct3 encodings, writeback states, load legality check
// Rev 1.0
// ----------------------------------------------------------------------------
package rv32i_pkg;

  localparam logic [2:0] c_F3_LB  = 3'd0;
  localparam logic [2:0] c_F3_LH  = 3'd1;
  localparam logic [2:0] c_F3_LW  = 3'd2;
  localparam logic [2:0] c_F3_LBU = 3'd4;
  localparam logic [2:0] c_F3_LHU = 3'd5;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } wb_state_t;

  // Misaligned halfword/word accesses and reserved encodings are rejected.
  function automatic logic load_bad(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3)
      c_F3_LB, c_F3_LBU: bad = 1'b0;
      c_F3_LH, c_F3_LHU: bad = off[0];
      c_F3_LW:           bad = (off != 2'd0);
      default:           bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// load_align: byte/half lane select and sign/zero extension of load data
// Rev 1.0
// ----------------------------------------------------------------------------
module load_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'd0;
    case (i_off)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = 8'd0;
    endcase
  end

  assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = 32'd0;
    case (i_funct3)
      c_F3_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      c_F3_LH:  o_data = {{16{w_half[15]}}, w_half};
      c_F3_LW:  o_data = i_rdata;
      c_F3_LBU: o_data = {24'd0, w_byte};
      c_F3_LHU: o_data = {16'd0, w_half};
      default:  o_data = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// writeback_unit: RV32I writeback with load wait; WB_TIMEOUT_EN adds load abort
// Rev 1.0
// ----------------------------------------------------------------------------
module writeback_unit
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_result,
  input  logic        ex_is_load,
  input  logic [2:0]  ex_funct3,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  rd_addr,
  output logic [31:0] w_val,
  output logic        retire,
  output logic        load_err
);

  wb_state_t   r_state, w_state_nxt;
  logic [4:0]  r_ld_rd;
  logic [2:0]  r_ld_f3;
  logic [1:0]  r_ld_off;
  logic        w_lat_en;
  logic [4:0]  w_rd_nxt;
  logic [31:0] w_val_nxt;
  logic        w_retire_nxt;
  logic        w_err_nxt;
  logic [31:0] w_aligned;
  logic        w_timeout;

  load_align u_align (
    .i_funct3 (r_ld_f3),
    .i_off    (r_ld_off),
    .i_rdata  (mem_rdata),
    .o_data   (w_aligned)
  );

`ifdef WB_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_cnt <= '0;
    else if (r_state == LOAD_WAIT)
      r_cnt <= r_cnt + 1'b1;
    else
      r_cnt <= '0;
  end

  assign w_timeout = (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_timeout        = 1'b0;
`endif

  assign ex_ready = (r_state == IDLE);

  always_comb begin
    w_state_nxt  = r_state;
    w_lat_en     = 1'b0;
    w_rd_nxt     = 5'd0;
    w_val_nxt    = 32'd0;
    w_retire_nxt = 1'b0;
    w_err_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (ex_valid) begin
          if (!ex_is_load) begin
            w_rd_nxt     = ex_rd;
            w_val_nxt    = ex_result;
            w_retire_nxt = 1'b1;
          end else if (load_bad(ex_funct3, ex_result[1:0])) begin
            w_err_nxt = 1'b1;
          end else begin
            w_lat_en    = 1'b1;
            w_state_nxt = LOAD_WAIT;
          end
        end
      end
      LOAD_WAIT: begin
        // A response on the last allowed cycle takes priority over the abort.
        if (mem_rvalid) begin
          w_rd_nxt     = r_ld_rd;
          w_val_nxt    = w_aligned;
          w_retire_nxt = 1'b1;
          w_state_nxt  = IDLE;
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_ld_rd  <= 5'd0;
      r_ld_f3  <= 3'd0;
      r_ld_off <= 2'd0;
      rd_addr  <= 5'd0;
      w_val    <= 32'd0;
      retire   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      rd_addr  <= w_rd_nxt;
      w_val    <= w_val_nxt;
      retire   <= w_retire_nxt;
      load_err <= w_err_nxt;
      if (w_lat_en) begin
        r_ld_rd  <= ex_rd;
        r_ld_f3  <= ex_funct3;
        r_ld_off <= ex_result[1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_writeback_unit: directed self-checking bench for writeback_unit
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_valid, ex_is_load, mem_rvalid;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result, mem_rdata;
  logic [2:0]  ex_funct3;
  logic        ex_ready, retire, load_err;
  logic [4:0]  rd_addr;
  logic [31:0] w_val;

  int n_vec = 0;
  int n_err = 0;
  logic [39:0] exp;
  wire  [39:0] obs = {ex_ready, retire, load_err, rd_addr, w_val};

  always #5 clk = ~clk;

  writeback_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clock(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rd(ex_rd), .ex_result(ex_result), .ex_is_load(ex_is_load),
    .ex_funct3(ex_funct3), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rd_addr(rd_addr), .w_val(w_val), .retire(retire), .load_err(load_err)
  );

  task automatic offer(input logic ld, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] res);
    ex_valid = 1'b1; ex_is_load = ld; ex_funct3 = f3; ex_rd = rd; ex_result = res;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_funct3 = 3'd0; ex_rd = 5'd0;
    ex_result = 32'd0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    exp = {1'b1, 1'b0, 1'b0, 5'd0, 32'd0};
    n_vec++; if (obs !== exp) begin n_err++; $display("FAIL reset: got %h want %h", obs, exp); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu();
    offer(1'b0, 3'd0, 5'd5, 32'h1234);
    @(negedge clk);
    idle_inputs();
    exp = {1'b1, 1'b1, 1'b0, 5'd5, 32'h0000_1234};
    n_vec++; if (obs !== exp) begin n_err++; $display("FAIL add: got %h want %h", obs, exp); end
    @(negedge clk);
    exp = {1'b1, 1'b0, 1'b0, 5'd0, 32'd0};
    n_vec++; if (obs !== exp) begin n_err++; $display("FAIL add_pulse: got %h want %h", obs, exp); end
    offer(1'b0, 3'd0, 5'd0, 32'hCAFE_F00D);
    @(negedge clk);
    idle_inputs();
    exp = {1'b1, 1'b1, 1'b0, 5'd0, 32'hCAFE_F00D};
    n_vec++; if (obs !== exp) begin n_err++; $display("FAIL rd_zero: got %h want %h", obs, exp); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      offer(1'b0, 3'd0, 5'(i + 10), 32'h100 + 32'(i));
      @(negedge clk);
      exp = {1'b1, 1'b1, 1'b0, 5'(i + 10), 32'h100 + 32'(i)};
      n_vec++; if (obs !== exp) begin n_err++; $display("FAIL b2b_%0d: got %h want %h", i, obs, exp); end
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic run_load(input string nm, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] addr, input logic [31:0] rdata,
                          input logic [31:0] want);
    offer(1'b1, f3, rd, addr);
    @(negedge clk);
    idle_inputs();
    exp = {1'b0, 1'b0, 1'b0, 5'd0, 32'd0};
    n_vec++; if (obs !== exp) begin n_err++; $display("FAIL %s_wait: got %h want %h", nm, obs, exp); end
    mem_rvalid = 1'b1; mem_rdata = rdata;
    @(negedge clk);
    idle_inputs();
    exp = {1'b1, 1'b1, 1'b0, rd, want};
    n_vec++; if (obs !== exp) begin n_err++; $display("FAIL %s: got %h want %h", nm, obs, exp); end
  endtask

  task automatic test_loads();
    run_load("lb",  3'd0, 5'd7,  32'h103, 32'h80FF_0000, 32'hFFFF_FF80);
    run_load("lbu", 3'd4, 5'd8,  32'h103, 32'h80FF_0000, 32'h0000_0080);
    run_load("lh",  3'd1, 5'd9,  32'h102, 32'h8001_5A5A, 32'hFFFF_8001);
    run_load("lhu", 3'd5, 5'd3,  32'h100, 32'h1234_F00D, 32'h0000_F00D);
    run_load("lw",  3'd2, 5'd31, 32'h200, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    run_load("lb1", 3'd0, 5'd2,  32'h101, 32'h0000_7F00, 32'h0000_007F);
  endtask

  task automatic test_misaligned();
    logic [2:0]  f3s [4] = '{3'd2, 3'd1, 3'd3, 3'd7};
    logic [31:0] ads [4] = '{32'h101, 32'h103, 32'h100, 32'h100};
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, f3s[i], 5'd6, ads[i]);
      @(negedge clk);
      idle_inputs();
      exp = {1'b1, 1'b0, 1'b1, 5'd0, 32'd0};
      n_vec++; if (obs !== exp) begin n_err++; $display("FAIL misalign_%0d: got %h want %h", i, obs, exp); end
    end
    @(negedge clk);
    exp = {1'b1, 1'b0, 1'b0, 5'd0, 32'd0};
    n_vec++; if (obs !== exp) begin n_err++; $display("FAIL err_pulse: got %h want %h", obs, exp); end
  endtask

  task automatic test_idle_rvalid();
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    idle_inputs();
    exp = {1'b1, 1'b0, 1'b0, 5'd0, 32'd0};
    n_vec++; if (obs !== exp) begin n_err++; $display("FAIL idle_rvalid: got %h want %h", obs, exp); end
  endtask

  task automatic test_timeout();
    int bad;
`ifdef WB_TIMEOUT_EN
    offer(1'b1, 3'd2, 5'd4, 32'h300);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      idle_inputs();
      if (ex_ready !== 1'b0 || load_err !== 1'b0) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL to_wait: %0d bad cycles want 0", bad); end
    @(negedge clk);
    exp = {1'b1, 1'b0, 1'b1, 5'd0, 32'd0};
    n_vec++; if (obs !== exp) begin n_err++; $display("FAIL timeout: got %h want %h", obs, exp); end
    offer(1'b1, 3'd2, 5'd4, 32'h300);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      idle_inputs();
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_CAFE;
    @(negedge clk);
    idle_inputs();
    exp = {1'b1, 1'b1, 1'b0, 5'd4, 32'h0BAD_CAFE};
    n_vec++; if (obs !== exp) begin n_err++; $display("FAIL to_last_win: got %h want %h", obs, exp); end
`else
    offer(1'b1, 3'd2, 5'd4, 32'h300);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      idle_inputs();
      if (ex_ready !== 1'b0 || load_err !== 1'b0) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL no_to_wait: %0d bad cycles want 0", bad); end
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_CAFE;
    @(negedge clk);
    idle_inputs();
    exp = {1'b1, 1'b1, 1'b0, 5'd4, 32'h0BAD_CAFE};
    n_vec++; if (obs !== exp) begin n_err++; $display("FAIL no_to_done: got %h want %h", obs, exp); end
`endif
  endtask

  task automatic test_reset_in_wait();
    offer(1'b0, 3'd0, 5'd12, 32'h5555_AAAA);
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b0;
    #1;
    exp = {1'b1, 1'b0, 1'b0, 5'd0, 32'd0};
    n_vec++; if (obs !== exp) begin n_err++; $display("FAIL async_rst: got %h want %h", obs, exp); end
    @(negedge clk);
    reset_n = 1'b1;
    offer(1'b1, 3'd2, 5'd13, 32'h400);
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b0;
    #1;
    n_vec++; if (obs !== exp) begin n_err++; $display("FAIL rst_wait: got %h want %h", obs, exp); end
    @(negedge clk);
    reset_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    idle_inputs();
    n_vec++; if (obs !== exp) begin n_err++; $display("FAIL rst_discard: got %h want %h", obs, exp); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_loads();
    test_misaligned();
    test_idle_rvalid();
    test_timeout();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
